// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control and timebase block for the stopwatch.
//   Debounces the start and lap buttons, runs the run/pause/lap/overflow
//   state machine, divides clk down to the hundredths-of-second tick, and
//   owns the 4-digit BCD running-time counter and the lap capture register.
//
// Ports:
//   clk            system clock, everything on the rising edge
//   rst            asynchronous active-high reset
//   btn_start_raw  raw start/stop button (asynchronous, active-high)
//   btn_lap_raw    raw lap/clear button (asynchronous, active-high)
//   time_bcd       running time  {tens s, s, tenths, hundredths}
//   lap_bcd        captured lap time, same format
//   run            1 while counting (RUNNING or LAP_HOLD)
//   show_lap       1 in LAP_HOLD; display shows lap_bcd
//   flash          1 in OVERFLOW; display blinks
//   state          FSM code: IDLE=0 RUNNING=1 PAUSED=2 LAP_HOLD=3 OVERFLOW=4
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_raw,
  input  logic        btn_lap_raw,
  output logic [15:0] time_bcd,
  output logic [15:0] lap_bcd,
  output logic        run,
  output logic        show_lap,
  output logic        flash,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUNNING  = 3'd1,
    S_PAUSED   = 3'd2,
    S_LAP_HOLD = 3'd3,
    S_OVERFLOW = 3'd4
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------
  // Button paths: bit 0 = start, bit 1 = lap.
  // ---------------------------------------------------------------
  logic [1:0] raw_vec;
  logic [1:0] press_vec;

  assign raw_vec = {btn_lap_raw, btn_start_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_vec[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            // Level has differed for DEBOUNCE_CYCLES cycles: accept it.
            // The press pulse lines up with the first cycle of the new level.
            level_reg <= sync2_reg;
            press_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign press_vec[gi] = press_reg;
    end
  endgenerate

  // Start wins when both presses land in the same cycle.
  logic start_p;
  logic lap_p;
  assign start_p = press_vec[0];
  assign lap_p   = press_vec[1] & ~press_vec[0];

  // ---------------------------------------------------------------
  // State, time, lap and prescaler registers.
  // ---------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [15:0]     time_reg, time_next;
  logic [15:0]     lap_reg, lap_next;
  logic [PS_W-1:0] presc_reg, presc_next;
  logic            run_reg, show_lap_reg, flash_reg;

  logic tick;
  assign tick = run_reg && (presc_reg == PS_LAST);

  // BCD increment as a ripple of per-digit carries; carry[4] set means
  // every digit is 9, i.e. the counter sits at 99.99.
  logic [15:0] time_inc;
  logic [4:0]  carry;
  logic        at_max;

  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit                 = time_reg[4*gi +: 4];
      assign time_inc[4*gi +: 4]   = !carry[gi]        ? digit :
                                     (digit == 4'd9)   ? 4'd0  : digit + 4'd1;
      assign carry[gi+1]           = carry[gi] & (digit == 4'd9);
    end
  endgenerate
  assign at_max = carry[4];

  always_comb begin
    state_next = state_reg;
    time_next  = time_reg;
    lap_next   = lap_reg;
    presc_next = presc_reg;

    // Prescaler only advances while counting, so a pause keeps the
    // partial tick and resuming continues from the same phase.
    if (run_reg) begin
      presc_next = tick ? '0 : presc_reg + PS_W'(1);
    end
    if (tick && !at_max) begin
      time_next = time_inc;
    end

    // An overflowing tick takes precedence over any button press.
    unique case (state_reg)
      S_IDLE: begin
        if (start_p) state_next = S_RUNNING;
      end
      S_RUNNING: begin
        if (tick && at_max) begin
          state_next = S_OVERFLOW;
        end else if (start_p) begin
          state_next = S_PAUSED;
        end else if (lap_p) begin
          state_next = S_LAP_HOLD;
          lap_next   = time_reg;   // pre-increment value on a coincident tick
        end
      end
      S_LAP_HOLD: begin
        if (tick && at_max) begin
          state_next = S_OVERFLOW;
        end else if (start_p) begin
          state_next = S_RUNNING;
        end else if (lap_p) begin
          lap_next = time_reg;
        end
      end
      S_PAUSED, S_OVERFLOW: begin
        if (state_reg == S_PAUSED && start_p) begin
          state_next = S_RUNNING;
        end else if (lap_p) begin
          state_next = S_IDLE;
          time_next  = '0;
          lap_next   = '0;
          presc_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      time_reg     <= '0;
      lap_reg      <= '0;
      presc_reg    <= '0;
      run_reg      <= 1'b0;
      show_lap_reg <= 1'b0;
      flash_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      time_reg     <= time_next;
      lap_reg      <= lap_next;
      presc_reg    <= presc_next;
      // Decoded from the next state so the flags line up with state.
      run_reg      <= (state_next == S_RUNNING) || (state_next == S_LAP_HOLD);
      show_lap_reg <= (state_next == S_LAP_HOLD);
      flash_reg    <= (state_next == S_OVERFLOW);
    end
  end

  assign time_bcd = time_reg;
  assign lap_bcd  = lap_reg;
  assign run      = run_reg;
  assign show_lap = show_lap_reg;
  assign flash    = flash_reg;
  assign state    = state_reg;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and timebase block for the stopwatch.
- Debounces the start and lap buttons, runs the run/pause/lap/overflow state machine, and generates the hundredths-of-second tick.
- Owns the 4-digit BCD running-time counter and the lap capture register.
- Drives run, show_lap, flash and both BCD buses into the display multiplexer.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per 0.01 s tick (100 MHz clk); must be >= 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new button level; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_start_raw  input  1  raw start/stop button, asynchronous, active-high
- btn_lap_raw  input  1  raw lap/clear button, asynchronous, active-high
- time_bcd  output  16  running time; [15:12] tens of s, [11:8] s, [7:4] tenths, [3:0] hundredths
- lap_bcd  output  16  captured lap time, same format
- run  output  1  1 while counting (RUNNING or LAP_HOLD)
- show_lap  output  1  1 in LAP_HOLD; display selects lap_bcd
- flash  output  1  1 in OVERFLOW; display blinks
- state  output  3  FSM state code: IDLE=0, RUNNING=1, PAUSED=2, LAP_HOLD=3, OVERFLOW=4

Behaviour:
- Reset is asynchronous. While rst is high and on release:
  - state=IDLE.
  - time_bcd=0, lap_bcd=0.
  - run, show_lap, flash = 0.
  - Prescaler, debounce counters, synchronizers and accepted levels all = 0.
- Button path (identical for each button):
  - 2-FF synchronizer feeds a debounce counter.
  - Counter increments each cycle while the synced level differs from the accepted level; it clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the accepted level takes the synced level and the counter clears.
  - A press is a 1-cycle pulse in the cycle the accepted level rises 0->1. Releases generate nothing.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Simultaneous start and lap press pulses in the same cycle: start acts, lap is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while run=1; it holds its value while paused, so no partial-tick loss.
  - It clears on entry to IDLE.
  - tick=1 for the one cycle the prescaler equals TICK_DIV-1, which then wraps to 0.
- Time counter:
  - On tick, time_bcd increments as BCD with digit carries 9->0.
  - Max value is 99.99 (16'h9999).
  - A tick at 9999: time stays 9999 and state becomes OVERFLOW on that edge.
- FSM transitions, all registered: each takes effect on the edge after the press pulse and is visible the next cycle.
  - IDLE:
    - start -> RUNNING.
    - lap ignored.
  - RUNNING:
    - start -> PAUSED.
    - lap -> LAP_HOLD and lap_bcd <= time_bcd.
    - overflow tick -> OVERFLOW.
  - LAP_HOLD:
    - Counting continues.
    - lap -> recapture lap_bcd and stay.
    - start -> RUNNING; the live view returns and counting does not stop.
    - overflow tick -> OVERFLOW.
  - PAUSED:
    - start -> RUNNING.
    - lap -> IDLE, clearing time_bcd, lap_bcd and the prescaler.
  - OVERFLOW:
    - start ignored.
    - lap -> IDLE with the same clear as PAUSED.
- Lap capture coincident with a tick: lap_bcd gets the pre-increment value; time_bcd increments normally.
- Outputs are registered decodes of state: run in {RUNNING, LAP_HOLD}, show_lap = LAP_HOLD, flash = OVERFLOW.
- Button held continuously yields exactly one press.
- Asserting rst mid-count or mid-debounce returns everything to reset values immediately, with no pulse after release.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
- Reset, then hold start 10 cycles -> exactly one press; state IDLE->RUNNING; run=1; time_bcd increments every 4 cycles: 0000, 0001, 0002.
- Start held 2 cycles then released (glitch) -> no press; state and time unchanged.
- Running at time 0009, press start -> time 0010 reached only if a tick precedes the transition; state PAUSED; time frozen for 40 cycles. Press start again -> resumes with prescaler continuity, next tick exactly 4 counting cycles total after the last.
- Running, press lap at time 0123 -> state LAP_HOLD, show_lap=1, lap_bcd=0123 while time_bcd keeps incrementing. Lap again at 0130 -> lap_bcd=0130. Press start -> RUNNING, show_lap=0.
- Preload time to 9998 via run (or force), two ticks -> time 9999 then OVERFLOW, flash=1, run=0, time stays 9999. Press start -> no change. Press lap -> IDLE, time_bcd=0000, lap_bcd=0000, flash=0.
- Press start and lap simultaneously from RUNNING -> PAUSED, lap_bcd unchanged. Assert rst during RUNNING at 0042 -> all outputs 0 and state IDLE asynchronously.
